data_mem_responder: RTL and testbench

Multi-cycle data memory that answers load/store requests issued by the pipeline's memory stage. It accepts one request at a time and holds `active` high while the access is in progress, so the pipeline stalls. After a fixed latency it returns load data with a one-cycle `done` pulse. The block sits behind the MEM stage and holds the word-addressed data store.

---
 rtl/data_mem_responder.sv | 130 +++++++++++++
 tb/tb_data_mem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle word-addressed data store behind the MEM stage.
// One request at a time; stalls the pipeline via active, finishes with a done pulse.
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memToRegM,
  input  logic        memWriteM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] writeDataM,
  output logic        active,
  output logic        done,
  output logic [31:0] readDataM,
  output logic        memErr
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_d;

  logic [CNT_W-1:0]  count, count_d;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              rd_q;
  logic              wr_q;
  logic              req;
  logic              accept;
  logic              fire;
  logic              fault;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rdata_d;
  logic [31:0]       mem [DEPTH];

  assign req = memToRegM | memWriteM;
  assign idx = addr_q[ADDR_W+1:2];

  // Range check uses the full word address so high bits cannot alias into the store.
  assign fault = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= DEPTH_W);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_d;
      count <= count_d;
    end
  end

  always_comb begin
    state_d = state;
    count_d = count;
    accept  = 1'b0;
    fire    = 1'b0;
    active  = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          accept  = 1'b1;
          active  = 1'b1;
          count_d = CNT_INIT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        active = 1'b1;
        if (count == '0) begin
          fire    = 1'b1;
          state_d = DONE;
        end else begin
          count_d = count - CNT_W'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load+store returns the old word; a pure store echoes its data.
  always_comb begin
    rdata_d = '0;
    if (!fault) begin
      if (wr_q && !rd_q) rdata_d = wdata_q;
      else               rdata_d = mem[idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      readDataM <= '0;
      memErr    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= ALUOutM;
        wdata_q <= writeDataM;
        rd_q    <= memToRegM;
        wr_q    <= memWriteM;
      end
      if (fire) begin
        readDataM <= rdata_d;
        memErr    <= fault;
      end
    end
  end

  // Storage is not reset; an aborted access never reaches fire.
  always_ff @(posedge clk) begin
    if (fire && wr_q && !fault) mem[idx] <= wdata_q;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: vector table, corner sequences,
// and randomized accesses against an array-based reference store.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int ADDR_W = 10;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memToRegM;
  logic        memWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] writeDataM;
  logic        active;
  logic        done;
  logic [31:0] readDataM;
  logic        memErr;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];

  data_mem_responder #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .memToRegM(memToRegM),
    .memWriteM(memWriteM),
    .ALUOutM(ALUOutM),
    .writeDataM(writeDataM),
    .active(active),
    .done(done),
    .readDataM(readDataM),
    .memErr(memErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] xd;
    logic        xe;
  } vec_t;

  vec_t tbl [12];

  task automatic check32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic model(input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] d, output logic e);
    int unsigned w;
    w = a >> 2;
    e = (a % 4 != 0) || (w >= DEPTH);
    d = 32'h0;
    if (!e) begin
      if (wr) begin
        d = rd ? ref_mem[w] : wd;
        ref_mem[w] = wd;
      end else begin
        d = ref_mem[w];
      end
    end
  endtask

  // Starts and ends at posedge+1 with the DUT idle.
  task automatic do_access(input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] d, output logic e);
    int cyc;
    bit busy_ok;
    bit got;
    logic [31:0] junk;
    memToRegM  = rd;
    memWriteM  = wr;
    ALUOutM    = a;
    writeDataM = wd;
    #1;
    check32("active_req", {31'b0, active}, 32'd1);
    busy_ok = 1'b1;
    got = 1'b0;
    cyc = 0;
    d = '0;
    e = 1'b0;
    while (!got && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      junk = $urandom;
      memToRegM  = junk[0];
      memWriteM  = junk[1];
      ALUOutM    = $urandom;
      writeDataM = $urandom;
      #1;
      if (done) begin
        got = 1'b1;
        d = readDataM;
        e = memErr;
        check32("latency", cyc, LAT + 1);
        check32("active_done", {31'b0, active}, 32'd0);
      end else if (!active) begin
        busy_ok = 1'b0;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got none want done within 20");
    end
    check32("active_busy", {31'b0, busy_ok}, 32'd1);
    memToRegM = 1'b0;
    memWriteM = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    logic [31:0] xd;
    logic        xe;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] tmp;
    int op;
    int kind;
    int c;

    tbl[0]  = '{1'b0, 1'b1, 32'h0,    32'h1111_0000, 32'h1111_0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 32'h4,    32'h0000_0001, 32'h0000_0001, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h4,    32'h0,         32'h0000_0001, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h5,    32'h0,         32'h0,         1'b1};
    tbl[4]  = '{1'b0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 32'h0,         1'b1};
    tbl[5]  = '{1'b1, 1'b0, 32'h0,    32'h0,         32'h1111_0000, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h8,    32'hAAAA_5555, 32'hAAAA_5555, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 32'h8,    32'h1234_5678, 32'hAAAA_5555, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h8,    32'h0,         32'h1234_5678, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 32'hC,    32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 32'h6,    32'h0000_0099, 32'h0,         1'b1};
    tbl[11] = '{1'b1, 1'b0, 32'h4,    32'h0,         32'h0000_0001, 1'b0};

    reset = 1'b1;
    memToRegM = 1'b0;
    memWriteM = 1'b0;
    ALUOutM = '0;
    writeDataM = '0;
    repeat (2) @(posedge clk);
    #1;
    check32("rst_active", {31'b0, active}, 32'd0);
    check32("rst_done", {31'b0, done}, 32'd0);
    check32("rst_rdata", readDataM, 32'h0);
    check32("rst_err", {31'b0, memErr}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      do_access(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, d, e);
      check32($sformatf("tbl%0d_data", i), d, tbl[i].xd);
      check32($sformatf("tbl%0d_err", i), {31'b0, e}, {31'b0, tbl[i].xe});
      model(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, xd, xe);
    end

    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      model(1'b0, 1'b1, 32'(i * 4), wd, xd, xe);
      do_access(1'b0, 1'b1, 32'(i * 4), wd, d, e);
      check32("init_data", d, xd);
    end

    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 2);
      kind = $urandom_range(0, 9);
      tmp = $urandom;
      if (kind < 7) begin
        a = 32'($urandom_range(0, 15)) << 2;
      end else if (kind < 9) begin
        a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      end else if (tmp[0]) begin
        a = 32'($urandom_range(DEPTH, 4095)) << 2;
      end else begin
        a = {1'b1, tmp[30:2], 2'b00};
      end
      wd = $urandom;
      model(op != 1, op != 0, a, wd, xd, xe);
      do_access(op != 1, op != 0, a, wd, d, e);
      check32($sformatf("rnd%0d_data a=%h", i, a), d, xd);
      check32($sformatf("rnd%0d_err a=%h", i, a), {31'b0, e}, {31'b0, xe});
    end

    memToRegM = 1'b0;
    memWriteM = 1'b1;
    ALUOutM = 32'hC;
    writeDataM = 32'hDEAD_BEEF;
    #1;
    check32("abort_active0", {31'b0, active}, 32'd1);
    @(posedge clk);
    #1;
    memWriteM = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check32("abort_active", {31'b0, active}, 32'd0);
    check32("abort_done", {31'b0, done}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check32("abort_rdata", readDataM, 32'h0);
    check32("abort_err", {31'b0, memErr}, 32'd0);
    model(1'b1, 1'b0, 32'hC, 32'h0, xd, xe);
    do_access(1'b1, 1'b0, 32'hC, 32'h0, d, e);
    check32("abort_kept", d, xd);

    model(1'b1, 1'b0, 32'h4, 32'h0, xd, xe);
    memToRegM = 1'b1;
    ALUOutM = 32'h4;
    for (c = 0; c < 40; c++) begin
      #1;
      check32($sformatf("hold_done c%0d", c), {31'b0, done},
              {31'b0, (c % (LAT + 2)) == LAT + 1});
      check32($sformatf("hold_active c%0d", c), {31'b0, active},
              {31'b0, (c % (LAT + 2)) != LAT + 1});
      if ((c % (LAT + 2)) == LAT + 1) check32("hold_rdata", readDataM, xd);
      @(posedge clk);
      #1;
    end
    memToRegM = 1'b0;
    repeat (8) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
